// File: rtl/w_forward_merger_pkg.sv
// ---------------------------------------------------------------------------
// w_forward_merger_pkg
// Shared definitions for the AW/W forward merger:
//   - stream / field width constants
//   - FSM state type {CMD, DAT}
//   - pack helpers for the command beat and the data beat
// ---------------------------------------------------------------------------
package w_forward_merger_pkg;

    localparam int DATA_W = 77;
    localparam int ID_W   = 8;
    localparam int ADDR_W = 36;
    localparam int DW     = 64;
    localparam int STRB_W = 8;
    localparam int USER_W = 4;
    localparam int LEN_W  = 8;

    typedef enum logic {
        CMD = 1'b0,
        DAT = 1'b1
    } wfm_state_t;

    // Command beat, MSB to LSB: ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE,
    // PROT, QOS, REGION, USER (8+36+8+3+2+1+4+3+4+4+4 = 77 bits).
    function automatic logic [DATA_W-1:0] pack_cmd(
        input logic [ID_W-1:0]   id,
        input logic [ADDR_W-1:0] addr,
        input logic [LEN_W-1:0]  len,
        input logic [2:0]        size,
        input logic [1:0]        burst,
        input logic              lock,
        input logic [3:0]        cache,
        input logic [2:0]        prot,
        input logic [3:0]        qos,
        input logic [3:0]        region,
        input logic [USER_W-1:0] user
    );
        return {id, addr, len, size, burst, lock, cache, prot, qos, region, user};
    endfunction

    // Data beat, MSB to LSB: DATA, STRB, USER, last (last in bit 0).
    function automatic logic [DATA_W-1:0] pack_dat(
        input logic [DW-1:0]     data,
        input logic [STRB_W-1:0] strb,
        input logic [USER_W-1:0] user,
        input logic              last
    );
        return {data, strb, user, last};
    endfunction

endpackage

// File: rtl/w_forward_merger_skid.sv
// ---------------------------------------------------------------------------
// wfm_skid_buf
// Two-entry skid buffer. Output data/valid and the not-full flag all come
// straight from flops, so upstream ready never sees a combinational path
// from the downstream READY.
// Ports:
//   CLK, RESETn   clock, asynchronous active-low reset
//   i_push        write strobe (ignored while full)
//   i_data        write data
//   o_not_full    registered "fewer than 2 entries" flag
//   o_valid       head entry valid
//   o_data        head entry data (0 after reset)
//   i_ready       downstream accepts head when o_valid
// ---------------------------------------------------------------------------
module wfm_skid_buf #(
    parameter int WIDTH = 77
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_not_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_cnt;
    logic             r_valid;
    logic             r_not_full;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_cnt_nxt;

    assign w_pop  = r_valid && i_ready;
    assign w_push = i_push && r_not_full;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_not_full <= 1'b1;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_data;
                    else               r_tail <= i_data;
                end
                2'b01: begin
                    r_head <= r_tail;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new beat
                    // lands behind whatever remains after the pop.
                    if (r_cnt == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
            r_cnt      <= w_cnt_nxt;
            r_valid    <= (w_cnt_nxt != 2'd0);
            r_not_full <= (w_cnt_nxt != 2'd2);
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_head;
    assign o_not_full = r_not_full;

endmodule

// File: rtl/w_forward_merger.sv
// ---------------------------------------------------------------------------
// w_forward_merger
// Serialises AXI write transactions (AW + W) onto a single 77-bit stream:
// one command beat followed by the data beats, the final beat carrying
// last=1 in bit 0. Output is registered through a 2-entry skid buffer.
// Ports:
//   CLK, RESETn            clock, asynchronous active-low reset
//   AW*                    AXI write-address slave channel
//   W*                     AXI write-data slave channel
//   DATA/VALID/READY       merged output stream
//   LEN_ERR                one-cycle pulse on a WLAST/AWLEN mismatch
// Build option:
//   WFM_LEN_CHECK_EN       derive last from an AWLEN beat counter and
//                          flag WLAST mismatches on LEN_ERR; when undefined
//                          last = WLAST and LEN_ERR is tied low.
// ---------------------------------------------------------------------------
module w_forward_merger
    import w_forward_merger_pkg::*;
(
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [LEN_W-1:0]  AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWLOCK,
    input  logic [3:0]        AWCACHE,
    input  logic [2:0]        AWPROT,
    input  logic [3:0]        AWQOS,
    input  logic [3:0]        AWREGION,
    input  logic [USER_W-1:0] AWUSER,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DW-1:0]     WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic [USER_W-1:0] WUSER,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [DATA_W-1:0] DATA,
    output logic              VALID,
    input  logic              READY,
    output logic              LEN_ERR
);

    wfm_state_t        r_state;
    wfm_state_t        w_state_nxt;
    logic              r_rdy_en;
    logic              w_not_full;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_last;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;

    // Holds both readies low until the first clock edge after reset release.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) r_rdy_en <= 1'b0;
        else         r_rdy_en <= 1'b1;
    end

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID && WREADY;

`ifdef WFM_LEN_CHECK_EN
    logic [LEN_W-1:0] r_beat_cnt;
    logic             r_len_err;

    assign w_last = (r_beat_cnt == '0);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            if (w_aw_hs)     r_beat_cnt <= AWLEN;
            else if (w_w_hs) r_beat_cnt <= r_beat_cnt - 8'd1;
            r_len_err <= w_w_hs && (WLAST != w_last);
        end
    end

    assign LEN_ERR = r_len_err;
`else
    assign w_last  = WLAST;
    assign LEN_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) r_state <= CMD;
        else         r_state <= w_state_nxt;
    end

    // Readies depend only on state and registered buffer status, never on
    // the VALID inputs.
    always_comb begin
        w_state_nxt = r_state;
        AWREADY     = 1'b0;
        WREADY      = 1'b0;
        unique case (r_state)
            CMD: begin
                AWREADY = r_rdy_en && w_not_full;
                if (AWVALID && AWREADY) w_state_nxt = DAT;
            end
            DAT: begin
                WREADY = r_rdy_en && w_not_full;
                if (WVALID && WREADY && w_last) w_state_nxt = CMD;
            end
            default: w_state_nxt = CMD;
        endcase
    end

    assign w_push      = w_aw_hs || w_w_hs;
    assign w_push_data = (r_state == CMD)
                       ? pack_cmd(AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK,
                                  AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER)
                       : pack_dat(WDATA, WSTRB, WUSER, w_last);

    wfm_skid_buf #(
        .WIDTH (DATA_W)
    ) u_skid (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .i_push     (w_push),
        .i_data     (w_push_data),
        .o_not_full (w_not_full),
        .o_valid    (VALID),
        .o_data     (DATA),
        .i_ready    (READY)
    );

endmodule

// File: tb/tb_w_forward_merger.sv
module tb_w_forward_merger;
    import w_forward_merger_pkg::*;

    logic              CLK = 1'b0;
    logic              RESETn = 1'b0;
    logic [7:0]        AWID;
    logic [35:0]       AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWLOCK;
    logic [3:0]        AWCACHE;
    logic [2:0]        AWPROT;
    logic [3:0]        AWQOS;
    logic [3:0]        AWREGION;
    logic [3:0]        AWUSER;
    logic              AWVALID;
    logic              AWREADY;
    logic [63:0]       WDATA;
    logic [7:0]        WSTRB;
    logic [3:0]        WUSER;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] DATA;
    logic              VALID;
    logic              READY;
    logic              LEN_ERR;

    always #5 CLK = ~CLK;

    w_forward_merger dut (
        .CLK(CLK), .RESETn(RESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWQOS(AWQOS), .AWREGION(AWREGION), .AWUSER(AWUSER),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WUSER(WUSER), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .DATA(DATA), .VALID(VALID), .READY(READY), .LEN_ERR(LEN_ERR)
    );

    typedef struct {
        logic [7:0]  id;
        logic [35:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [3:0]  user;
        int unsigned dly;
    } aw_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [3:0]  user;
        logic        last;
    } w_t;

    aw_t               aw_q[$];
    w_t                w_q[$];
    logic [DATA_W-1:0] sb[$];
    longint            pop_cyc[$];
    longint            cyc = 0;
    int                n_chk = 0;
    int                n_fail = 0;
    int                len_err_seen = 0;
    int                len_err_exp = 0;
    logic              flush = 1'b0;
    int                ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a transaction is one command beat then AWLEN+1 data
    // beats; the emitted last flag is set exactly on beat index AWLEN.
    task automatic issue(input logic [7:0] id, input logic [7:0] len,
                         input int unsigned dly, input int unsigned nbeats,
                         input bit bad_last0);
        aw_t a;
        w_t  w;
        a.id     = id;
        a.addr   = 36'({$urandom(), $urandom()});
        a.len    = len;
        a.size   = 3'($urandom());
        a.burst  = 2'($urandom());
        a.lock   = 1'($urandom());
        a.cache  = 4'($urandom());
        a.prot   = 3'($urandom());
        a.qos    = 4'($urandom());
        a.region = 4'($urandom());
        a.user   = 4'($urandom());
        a.dly    = dly;
        aw_q.push_back(a);
        sb.push_back({a.id, a.addr, a.len, a.size, a.burst, a.lock, a.cache,
                      a.prot, a.qos, a.region, a.user});
        for (int unsigned i = 0; i < nbeats; i++) begin
            w.data = {$urandom(), $urandom()};
            w.strb = 8'($urandom());
            w.user = 4'($urandom());
            w.last = (i == 32'(len));
            if (bad_last0 && i == 0) w.last = ~w.last;
            if (w.last != (i == 32'(len))) len_err_exp++;
            w_q.push_back(w);
            sb.push_back({w.data, w.strb, w.user, 1'(i == 32'(len))});
        end
    endtask

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while ((sb.size() != 0 || aw_q.size() != 0 || w_q.size() != 0) && n < 3000) begin
            @(posedge CLK);
            n++;
        end
        check({name, "_drained"}, DATA_W'(sb.size()), '0);
        @(posedge CLK);
        #2;
    endtask

    task automatic check_back_to_back(input string name, input int n);
        int base;
        check({name, "_count"}, DATA_W'(pop_cyc.size()), DATA_W'(n));
        base = pop_cyc.size() - n;
        if (base < 0) base = 0;
        for (int k = base; k + 1 < pop_cyc.size(); k++)
            check({name, "_no_bubble"}, DATA_W'(pop_cyc[k+1] - pop_cyc[k]), DATA_W'(1));
    endtask

    // AW channel driver: handshake is predicted at the negedge (AWREADY is
    // registered, so it holds through the following posedge).
    initial begin : aw_drv
        aw_t a;
        bit  pend;
        int unsigned stall, dcnt;
        pend = 0; stall = 0; dcnt = 0;
        AWVALID = 0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        AWLOCK = 0; AWCACHE = '0; AWPROT = '0; AWQOS = '0; AWREGION = '0; AWUSER = '0;
        forever begin
            @(negedge CLK);
            if (flush) begin
                AWVALID = 0; pend = 0; stall = 0; dcnt = 0;
            end else begin
                if (pend) begin AWVALID = 0; pend = 0; end
                if (!AWVALID && aw_q.size() > 0) begin
                    if (dcnt < aw_q[0].dly) dcnt++;
                    else begin
                        a = aw_q.pop_front();
                        dcnt = 0; stall = 0;
                        AWID = a.id; AWADDR = a.addr; AWLEN = a.len; AWSIZE = a.size;
                        AWBURST = a.burst; AWLOCK = a.lock; AWCACHE = a.cache;
                        AWPROT = a.prot; AWQOS = a.qos; AWREGION = a.region;
                        AWUSER = a.user; AWVALID = 1;
                    end
                end
                if (AWVALID) begin
                    pend = AWREADY;
                    if (!pend) begin
                        stall++;
                        if (stall > 400) begin
                            check("aw_handshake_timeout", '0, DATA_W'(1));
                            AWVALID = 0; stall = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : w_drv
        w_t  w;
        bit  pend;
        int unsigned stall;
        pend = 0; stall = 0;
        WVALID = 0; WDATA = '0; WSTRB = '0; WUSER = '0; WLAST = 0;
        forever begin
            @(negedge CLK);
            if (flush) begin
                WVALID = 0; pend = 0; stall = 0;
            end else begin
                if (pend) begin WVALID = 0; pend = 0; end
                if (!WVALID && w_q.size() > 0) begin
                    w = w_q.pop_front();
                    stall = 0;
                    WDATA = w.data; WSTRB = w.strb; WUSER = w.user; WLAST = w.last;
                    WVALID = 1;
                end
                if (WVALID) begin
                    pend = WREADY;
                    if (!pend) begin
                        stall++;
                        if (stall > 400) begin
                            check("w_handshake_timeout", '0, DATA_W'(1));
                            WVALID = 0; stall = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : ready_drv
        READY = 0;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       READY = 0;
                1:       READY = 1;
                default: READY = ($urandom_range(99) < 70);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks
    // that a stalled beat stays valid and unchanged.
    initial begin : mon
        logic [DATA_W-1:0] prev_data;
        logic [DATA_W-1:0] e;
        bit prev_stall;
        prev_stall = 0;
        prev_data = '0;
        forever begin
            @(negedge CLK);
            if (!RESETn || flush) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("valid_held", DATA_W'(VALID), DATA_W'(1));
                    check("data_stable", DATA, prev_data);
                end
                if (VALID && READY) begin
                    if (sb.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_beat: got %h, expected no beat", DATA);
                    end else begin
                        e = sb.pop_front();
                        check("beat", DATA, e);
                        pop_cyc.push_back(cyc);
                    end
                end
                prev_stall = VALID && !READY;
                prev_data  = DATA;
                if (LEN_ERR) len_err_seen++;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        #1;
        check("rst_valid",   DATA_W'(VALID),   '0);
        check("rst_data",    DATA,             '0);
        check("rst_len_err", DATA_W'(LEN_ERR), '0);
        check("rst_awready", DATA_W'(AWREADY), '0);
        check("rst_wready",  DATA_W'(WREADY),  '0);
        repeat (3) @(posedge CLK);
        #2;
        RESETn = 1;
        #1;
        check("awready_before_edge", DATA_W'(AWREADY), '0);
        @(posedge CLK);
        #1;
        check("awready_after_edge", DATA_W'(AWREADY), DATA_W'(1));
        #1;

        // AWID=0x12, AWLEN=3: five beats on consecutive cycles.
        pop_cyc.delete();
        issue(8'h12, 8'd3, 0, 4, 0);
        wait_drain("len3_burst");
        check_back_to_back("len3_burst", 5);

        // W presented three cycles before AW.
        issue(8'h34, 8'd2, 3, 3, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            check("wready_before_aw", DATA_W'(WREADY), '0);
        end
        wait_drain("w_before_aw");

        // Output stalled for four cycles mid-burst.
        ready_mode = 0;
        issue(8'h56, 8'd3, 0, 4, 0);
        repeat (4) @(negedge CLK);
        #1;
        check("stall_awready", DATA_W'(AWREADY), '0);
        check("stall_wready",  DATA_W'(WREADY),  '0);
        check("stall_valid",   DATA_W'(VALID),   DATA_W'(1));
        @(posedge CLK);
        #2;
        ready_mode = 1;
        wait_drain("stall_burst");

        // Back-to-back single-beat transactions.
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) issue(8'(i), 8'd0, 0, 1, 0);
        wait_drain("len0_b2b");
        check_back_to_back("len0_b2b", 16);

        // Reset mid-burst of an AWLEN=7 transaction with two beats buffered.
        issue(8'h78, 8'd7, 0, 2, 0);
        wait_drain("pre_reset");
        ready_mode = 0;
        begin
            w_t w;
            for (int i = 0; i < 2; i++) begin
                w.data = {$urandom(), $urandom()};
                w.strb = 8'hff; w.user = 4'h0; w.last = 0;
                w_q.push_back(w);
            end
        end
        repeat (5) @(posedge CLK);
        #2;
        check("prereset_valid", DATA_W'(VALID), DATA_W'(1));
        flush = 1;
        aw_q.delete(); w_q.delete(); sb.delete();
        AWVALID = 0; WVALID = 0;
        RESETn = 0;
        #1;
        check("midrst_valid",   DATA_W'(VALID),   '0);
        check("midrst_data",    DATA,             '0);
        check("midrst_awready", DATA_W'(AWREADY), '0);
        check("midrst_wready",  DATA_W'(WREADY),  '0);
        repeat (2) @(posedge CLK);
        #2;
        RESETn = 1;
        ready_mode = 1;
        @(posedge CLK);
        #2;
        flush = 0;
        repeat (2) begin
            @(negedge CLK);
            #1;
            check("postrst_no_stale", DATA_W'(VALID), '0);
        end
        issue(8'h9a, 8'd2, 0, 3, 0);
        wait_drain("post_reset");

`ifdef WFM_LEN_CHECK_EN
        // AWLEN=1 with WLAST=1 on beat 0: counter drives last, LEN_ERR flags it.
        issue(8'hbc, 8'd1, 0, 2, 1);
        wait_drain("len_mismatch");
`endif

        // Randomised traffic with random backpressure.
        ready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            logic [7:0] l;
            l = 8'($urandom_range(7));
            issue(8'($urandom()), l, $urandom_range(3), 32'(l) + 1, 0);
        end
        wait_drain("random");
        ready_mode = 1;

        check("len_err_pulses", DATA_W'(len_err_seen), DATA_W'(len_err_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/w_forward_merger.md
W_FORWARD_MERGER -- requirements
Module: w_forward_merger

Interface
REQ-001 The block SHALL use clock CLK (input, 1 bit): all state is updated on its rising edge.
REQ-002 The block SHALL use reset RESETn (input, 1 bit): asynchronous, active-low.
REQ-003 The block SHALL have the following AW slave input ports:
  - AWID 8, AWADDR 36, AWLEN 8, AWSIZE 3, AWBURST 2, AWLOCK 1, AWCACHE 4, AWPROT 3, AWQOS 4, AWREGION 4, AWUSER 4, AWVALID 1 (all inputs);
  - AWREADY 1 (output).
REQ-004 The block SHALL have the following W slave input ports:
  - WDATA 64, WSTRB 8, WUSER 4, WLAST 1, WVALID 1 (all inputs);
  - WREADY 1 (output).
REQ-005 The block SHALL have the following merged stream output ports:
  - DATA 77 (output);
  - VALID 1 (output);
  - READY 1 (input).
REQ-006 The block SHALL have LEN_ERR (output, 1 bit): a one-cycle pulse that flags a burst-length mismatch (see Configuration).

Function
REQ-010 The block SHALL serialize each write transaction onto DATA as one command beat followed by its data beats, ending with the beat that carries last=1.
REQ-011 The command beat SHALL be packed MSB-to-LSB as {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER}, which is exactly 77 bits.
REQ-012 A data beat SHALL be packed MSB-to-LSB as {WDATA, WSTRB, WUSER, last}, with the last flag in bit 0.
REQ-013 The block SHALL have a two-state FSM with states CMD and DAT.
  - CMD -> DAT on an AWVALID&&AWREADY handshake.
  - DAT -> CMD on a WVALID&&WREADY handshake whose packed last bit is 1.
  - No other transitions.
REQ-014 In CMD, AWREADY SHALL equal the skid buffer's not-full signal, and WREADY SHALL be 0.
REQ-015 In DAT, WREADY SHALL equal the skid buffer's not-full signal, and AWREADY SHALL be 0.
REQ-016 If AWVALID and WVALID are both high in CMD, the block SHALL accept AW only; the W beat SHALL wait until the state is DAT.
REQ-017 If W arrives before its AW, the block SHALL hold WREADY=0 and SHALL NOT drop or reorder any beat.
REQ-018 The output SHALL be taken from a 2-entry skid buffer, so DATA and VALID are driven straight from flops.
REQ-019 An accepted beat SHALL appear on VALID in the next cycle, i.e. 1-cycle latency.
REQ-020 The block SHALL sustain 1 beat per cycle whenever READY is held high.
REQ-021 Once VALID is asserted, DATA SHALL remain stable until VALID&&READY, and VALID SHALL NOT deassert before that handshake.
REQ-022 When the skid buffer holds 2 entries, the block SHALL drive both AWREADY and WREADY to 0.
REQ-023 If a push and a pop occur in the same cycle while the buffer is full, the occupancy SHALL be unchanged and order SHALL be preserved.
REQ-024 AWREADY and WREADY SHALL NOT depend combinationally on AWVALID or WVALID.

Reset
REQ-030 While RESETn is low, the block SHALL drive:
  - VALID=0, DATA=0, LEN_ERR=0;
  - AWREADY=0, WREADY=0;
  - FSM state = CMD, skid buffer empty, beat counter = 0.
REQ-031 A reset asserted mid-burst SHALL discard the buffered beats and the partial transaction, and the block SHALL resume in CMD.
REQ-032 After reset is released, AWREADY SHALL assert no earlier than the first CLK edge.

Configuration
REQ-040 The macro WFM_LEN_CHECK_EN SHALL control burst-length checking.
REQ-041 With WFM_LEN_CHECK_EN defined, the block SHALL behave as follows:
  - an 8-bit beat counter is loaded with AWLEN on the AW handshake and decremented on each W handshake;
  - the emitted last bit = (counter==0), and the FSM uses this bit;
  - LEN_ERR pulses for 1 cycle whenever the incoming WLAST differs from (counter==0).
REQ-042 With WFM_LEN_CHECK_EN undefined, there SHALL be no counter, the last bit SHALL equal WLAST, and LEN_ERR SHALL be tied to 0.

Structure
REQ-050 A shared package SHALL hold:
  - width constants: DATA_W=77, ID_W=8, ADDR_W=36, DW=64, STRB_W=8, USER_W=4;
  - the FSM state typedef {CMD, DAT};
  - the pack functions for the command beat and the data beat.
REQ-051 The skid buffer SHALL be a separate sub-module named wfm_skid_buf, parameterized by width.

Verification
REQ-060 AWID=0x12, AWLEN=3 followed by 4 W beats, READY held 1 -> 5 beats out on consecutive cycles, with bit 0 = 0,0,0,0,1.
REQ-061 WVALID raised 3 cycles before AWVALID -> WREADY=0 until the AW handshake, and the output order is command beat first.
REQ-062 READY=0 for 4 cycles during a burst -> at most 2 beats held, AWREADY/WREADY drop, DATA stable, no loss; READY then returns to 1 and the sequence is intact.
REQ-063 RESETn pulsed low after beat 2 of an AWLEN=7 burst -> VALID=0, DATA=0 at once; the next AW is accepted and emitted first.
REQ-064 With WFM_LEN_CHECK_EN: AWLEN=1 and WLAST=1 on beat 0 -> emitted last=0, and LEN_ERR pulses 1 cycle on beat 0.
REQ-065 Back-to-back transactions with AWLEN=0, ready always 1 -> the output alternates command beat and data beat (last=1) every cycle with no bubbles.
